// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: nibble-to-byte assembler feeding a FIFO that issues one instruction per cycle
//
// Ports:
//   clk          rising-edge system clock
//   reset_n      asynchronous active-low reset
//   nib_in       4-bit nibble data, taken on a rising edge of nib_stb
//   nib_stb      nibble strobe (level); only its 0->1 transition counts
//   flush        synchronous clear of FIFO, assembler and overflow flag
//   issue_en     downstream can accept an instruction this cycle
//   instruction  last issued instruction byte
//   write_en     one-cycle pulse marking a newly issued instruction
//   full         FIFO holds DEPTH entries
//   empty        FIFO holds no entries
//   count        number of entries held
//   overflow     sticky flag: a completed byte was dropped while full
module instr_fetch_queue #(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        nib_in,
    input  logic              nib_stb,
    input  logic              flush,
    input  logic              issue_en,
    output logic [7:0]        instruction,
    output logic              write_en,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {LO_WAIT, HI_WAIT} asm_state_t;

    asm_state_t        state;
    logic              stb_q;
    logic [3:0]        lo_reg;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [7:0]        mem [DEPTH];
    logic              nib_take;
    logic              push;
    logic              pop;
    logic              accept;

    assign full     = count == (ADDR_W + 1)'(DEPTH);
    assign empty    = count == '0;
    assign nib_take = nib_stb & ~stb_q;
    assign push     = nib_take & (state == HI_WAIT) & ~flush;
    assign pop      = issue_en & ~empty & ~flush;
    // A full FIFO still takes the byte when an entry leaves in the same cycle.
    assign accept   = push & (~full | pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= LO_WAIT;
            stb_q       <= 1'b0;
            lo_reg      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            write_en    <= 1'b0;
            instruction <= 8'h00;
        end else begin
            // Strobe history tracks the pin even during flush so a held strobe is not re-taken.
            stb_q <= nib_stb;
            if (flush) begin
                state    <= LO_WAIT;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
                write_en <= 1'b0;
            end else begin
                write_en <= pop;
                if (pop) begin
                    instruction <= mem[rd_ptr];
                    rd_ptr      <= rd_ptr + 1'b1;
                end
                if (accept) wr_ptr <= wr_ptr + 1'b1;
                if (push && !accept) overflow <= 1'b1;
                count <= count + (ADDR_W + 1)'(accept) - (ADDR_W + 1)'(pop);
                if (nib_take) begin
                    if (state == LO_WAIT) lo_reg <= nib_in;
                    state <= (state == LO_WAIT) ? HI_WAIT : LO_WAIT;
                end
            end
        end
    end

    // Storage needs no reset; pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= {nib_in, lo_reg};
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: scoreboard bench with a queue-based reference model for instr_fetch_queue
module tb_instr_fetch_queue;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk;
    logic              reset_n;
    logic [3:0]        nib_in;
    logic              nib_stb;
    logic              flush;
    logic              issue_en;
    logic [7:0]        instruction;
    logic              write_en;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;

    instr_fetch_queue #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .nib_in(nib_in), .nib_stb(nib_stb),
        .flush(flush), .issue_en(issue_en), .instruction(instruction),
        .write_en(write_en), .full(full), .empty(empty), .count(count),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    logic [7:0] fifo [$];
    logic [7:0] exp_q [$];
    bit         m_half, m_prev, m_ovf, m_we;
    logic [3:0] m_lo;
    logic [7:0] m_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        fifo.delete();
        exp_q.delete();
        m_half  = 0;
        m_prev  = 0;
        m_ovf   = 0;
        m_we    = 0;
        m_lo    = '0;
        m_instr = 8'h00;
    endtask

    // Reference model: a byte queue plus a "half byte pending" flag.
    always @(posedge clk) begin : model
        bit take;
        logic [7:0] b;
        if (reset_n) begin
            take   = nib_stb && !m_prev;
            m_prev = nib_stb;
            if (flush) begin
                fifo.delete();
                m_half = 0;
                m_ovf  = 0;
                m_we   = 0;
            end else begin
                if (issue_en && fifo.size() > 0) begin
                    b = fifo.pop_front();
                    exp_q.push_back(b);
                    m_instr = b;
                    m_we    = 1;
                end else m_we = 0;
                if (take) begin
                    if (m_half) begin
                        m_half = 0;
                        if (fifo.size() < DEPTH) fifo.push_back({nib_in, m_lo});
                        else m_ovf = 1;
                    end else begin
                        m_lo   = nib_in;
                        m_half = 1;
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an instruction.
    always @(negedge clk) begin
        if (run) begin
            chk("write_en", write_en, m_we);
            if (write_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL issue: got %0h expected no issue at %0t", instruction, $time);
                end else chk("issued_instr", instruction, exp_q.pop_front());
            end
            chk("instruction", instruction, m_instr);
            chk("count", count, fifo.size());
            chk("full", full, fifo.size() == DEPTH);
            chk("empty", empty, fifo.size() == 0);
            chk("overflow", overflow, m_ovf);
        end
    end

    task automatic send_nib(input logic [3:0] n, input bit iss);
        @(negedge clk);
        nib_in  = n;
        nib_stb = 1'b1;
        if (iss) issue_en = 1'b1;
        @(negedge clk);
        nib_stb = 1'b0;
        if (iss) issue_en = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit iss_hi);
        send_nib(b[3:0], 1'b0);
        send_nib(b[7:4], iss_hi);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int pct;
        reset_n  = 1'b1;
        nib_in   = '0;
        nib_stb  = 1'b0;
        flush    = 1'b0;
        issue_en = 1'b0;
        model_reset();
        #1 reset_n = 1'b0;
        #2;
        chk("rst_instruction", instruction, 8'h00);
        chk("rst_write_en", write_en, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        idle(2);
        reset_n = 1'b1;
        run = 1'b1;

        // Single byte, low nibble first.
        issue_en = 1'b1;
        send_byte(8'hA3, 1'b0);
        idle(3);
        chk("t1_instr", instruction, 8'hA3);
        chk("t1_empty", empty, 1'b1);
        issue_en = 1'b0;

        // Fill to full, overflow on the ninth, then drain back-to-back.
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
        chk("t2_full", full, 1'b1);
        send_byte(8'h09, 1'b0);
        idle(1);
        chk("t2_overflow", overflow, 1'b1);
        chk("t2_count", count, 8);
        @(negedge clk) issue_en = 1'b1;
        idle(10);
        chk("t2_last", instruction, 8'h08);
        issue_en = 1'b0;

        // Five entries, then flush clears everything including overflow.
        for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i), 1'b0);
        idle(1);
        chk("t5_count5", count, 5);
        @(negedge clk) flush = 1'b1;
        @(negedge clk) flush = 1'b0;
        chk("t5_flush_count", count, 0);
        chk("t5_flush_ovf", overflow, 1'b0);

        // Full plus simultaneous pop: byte accepted, order kept across wrap.
        for (int i = 0; i < 8; i++) send_byte(8'h40 + 8'(i), 1'b0);
        send_byte(8'h48, 1'b1);
        idle(1);
        chk("t3_overflow", overflow, 1'b0);
        chk("t3_count", count, 8);
        @(negedge clk) issue_en = 1'b1;
        idle(10);
        chk("t3_last", instruction, 8'h48);

        // Partial nibble discarded by flush; nibble on flush cycle ignored.
        send_nib(4'hF, 1'b0);
        @(negedge clk);
        flush   = 1'b1;
        nib_stb = 1'b1;
        nib_in  = 4'hE;
        @(negedge clk);
        flush   = 1'b0;
        nib_stb = 1'b0;
        send_byte(8'h21, 1'b0);
        idle(2);
        chk("t5_instr", instruction, 8'h21);

        // Held strobe yields exactly one nibble.
        issue_en = 1'b0;
        @(negedge clk);
        nib_in  = 4'h7;
        nib_stb = 1'b1;
        idle(5);
        nib_stb = 1'b0;
        chk("t4_count", count, 0);
        send_nib(4'h5, 1'b0);
        idle(1);
        chk("t4_count1", count, 1);
        issue_en = 1'b1;
        idle(2);
        chk("t4_instr", instruction, 8'h57);

        // Randomized traffic with varying drain rates.
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) pct = (i / 250) % 3 == 0 ? 5 : (i / 250) % 3 == 1 ? 95 : 50;
            @(negedge clk);
            nib_stb  = 1'($urandom_range(0, 1));
            nib_in   = 4'($urandom);
            issue_en = $urandom_range(0, 99) < pct;
            flush    = $urandom_range(0, 199) == 0;
        end
        @(negedge clk);
        nib_stb  = 1'b0;
        flush    = 1'b1;
        issue_en = 1'b0;
        @(negedge clk) flush = 1'b0;

        // Asynchronous reset in the middle of an issue pulse.
        for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i), 1'b0);
        @(negedge clk) issue_en = 1'b1;
        @(posedge clk);
        #2 chk("t6_pulse", write_en, 1'b1);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("t6_write_en", write_en, 1'b0);
        chk("t6_instr", instruction, 8'h00);
        chk("t6_count", count, 0);
        issue_en = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(3);

        chk("scoreboard_drained", exp_q.size(), 0);
        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
